// File: rtl/iic_slave_if.sv
// rtl/iic_slave_if.sv - write-notification and status bundle of the I2C EEPROM target
//
// Purpose: carries the array-write notification and the busy flag from
//          iic_slave to whoever watches it.
// Signals:
//   wr_valid  one-cycle pulse when a data byte is written into the array
//   wr_addr   array index of that write
//   wr_data   byte written
//   busy      high from an address-matched START until STOP
// Modports:
//   slave   driven by iic_slave
//   master  observer side
interface iic_slave_if;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   modport slave  (output wr_valid, output wr_addr, output wr_data, output busy);
   modport master (input  wr_valid, input  wr_addr, input  wr_data, input  busy);
endinterface

// File: rtl/iic_slave.sv
// rtl/iic_slave.sv - I2C target emulating a 24Cxx-style EEPROM with a 256-byte array
//
// Purpose: oversamples SCL/SDA with sys_clk and answers reads/writes of an
//          internal 256-byte array. Never drives SCL.
// Ports:
//   sys_clk  system clock, at least 20x the SCL frequency
//   sys_rst  asynchronous active-low reset
//   scl      I2C clock from the master
//   sda      I2C data, driven 1'b0 or released (1'bz) only
//   wr_if    write-notification pulse (wr_valid/wr_addr/wr_data) and busy
module iic_slave #(
   parameter logic [6:0] DEVICE_ADDR = 7'b1010000,
   parameter bit         ADDR_16BIT  = 1'b1,
   parameter logic [7:0] INIT_VALUE  = 8'hFF
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       scl,
   inout  wire        sda,
   iic_slave_if.slave wr_if
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_DEV_ADDR,
      S_ACK_DEV,
      S_ADDR_H,
      S_ACK_ADDR_H,
      S_ADDR_L,
      S_ACK_ADDR_L,
      S_WR_DATA,
      S_ACK_WR,
      S_RD_DATA,
      S_RD_ACK,
      S_IGNORE
   } state_t;

   // [0] first sync stage, [1] synchronized value, [2] one-cycle-delayed copy
   logic [2:0] scl_pipe_q, scl_pipe_d;
   logic [2:0] sda_pipe_q, sda_pipe_d;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic       busy_q, busy_d;
   logic       wr_valid_q, wr_valid_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;

   logic [7:0] mem_q [256];
   logic       mem_we;

   logic       scl_now, scl_prev, sda_now, sda_prev;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte, rd_byte;

   assign sda = sda_oe_q ? 1'b0 : 1'bz;

   assign wr_if.wr_valid = wr_valid_q;
   assign wr_if.wr_addr  = wr_addr_q;
   assign wr_if.wr_data  = wr_data_q;
   assign wr_if.busy     = busy_q;

   assign scl_now  = scl_pipe_q[1];
   assign scl_prev = scl_pipe_q[2];
   assign sda_now  = sda_pipe_q[1];
   assign sda_prev = sda_pipe_q[2];

   assign scl_rise  = scl_now & ~scl_prev;
   assign scl_fall  = ~scl_now & scl_prev;
   // SDA edges count as bus conditions only while SCL is stable high
   assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
   assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

   // Byte as it stands once the current rising-edge bit is shifted in
   assign rx_byte = {shift_q[6:0], sda_now};
   assign rd_byte = mem_q[ptr_q];

   always_comb begin
      scl_pipe_d = {scl_pipe_q[1:0], scl};
      sda_pipe_d = {sda_pipe_q[1:0], sda};
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      mem_we     = 1'b0;

      if (stop_det) begin
         state_d   = S_IDLE;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = 4'd0;
      end else if (start_det) begin
         state_d   = S_DEV_ADDR;
         sda_oe_d  = 1'b0;
         bit_cnt_d = 4'd0;
      end else begin
         case (state_q)
            S_IDLE, S_IGNORE: begin
            end

            // Receive phase shared by every byte the master sends. The byte
            // completes on the 8th rise; the ACK starts on the following fall.
            S_DEV_ADDR, S_ADDR_H, S_ADDR_L, S_WR_DATA: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     case (state_q)
                        S_DEV_ADDR: begin
                           if (rx_byte[7:1] == DEVICE_ADDR) begin
                              busy_d = 1'b1;
                              rw_d   = rx_byte[0];
                           end else begin
                              state_d   = S_IGNORE;
                              bit_cnt_d = 4'd0;
                           end
                        end
                        S_ADDR_L: ptr_d = rx_byte;
                        S_WR_DATA: begin
                           mem_we     = 1'b1;
                           wr_valid_d = 1'b1;
                           wr_addr_d  = ptr_q;
                           wr_data_d  = rx_byte;
                           ptr_d      = ptr_q + 8'd1;
                        end
                        default: begin
                           // high address byte: the array only uses 8 bits
                        end
                     endcase
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_oe_d  = 1'b1;
                  bit_cnt_d = 4'd0;
                  case (state_q)
                     S_DEV_ADDR: state_d = S_ACK_DEV;
                     S_ADDR_H:   state_d = S_ACK_ADDR_H;
                     S_ADDR_L:   state_d = S_ACK_ADDR_L;
                     default:    state_d = S_ACK_WR;
                  endcase
               end
            end

            // ACK is held low across one full SCL period, released on the next fall
            S_ACK_DEV: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  if (rw_q) begin
                     state_d   = S_RD_DATA;
                     shift_d   = rd_byte;
                     sda_oe_d  = ~rd_byte[7];
                     bit_cnt_d = 4'd0;
                  end else begin
                     state_d = ADDR_16BIT ? S_ADDR_H : S_ADDR_L;
                  end
               end
            end

            S_ACK_ADDR_H: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = S_ADDR_L;
               end
            end

            S_ACK_ADDR_L, S_ACK_WR: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = S_WR_DATA;
               end
            end

            // shift_q[7] is the bit currently on the bus; rotate on each fall
            S_RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d  = 1'b0;
                     ptr_d     = ptr_q + 8'd1;
                     state_d   = S_RD_ACK;
                     bit_cnt_d = 4'd0;
                  end else begin
                     shift_d  = {shift_q[6:0], shift_q[7]};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end

            // NACK leaves at the rise; only an ACK survives to the next fall
            S_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_now) begin
                     state_d = S_IGNORE;
                  end
               end else if (scl_fall) begin
                  state_d   = S_RD_DATA;
                  shift_d   = rd_byte;
                  sda_oe_d  = ~rd_byte[7];
                  bit_cnt_d = 4'd0;
               end
            end

            default: begin
               state_d  = S_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         scl_pipe_q <= 3'b111;
         sda_pipe_q <= 3'b111;
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'd0;
         ptr_q      <= 8'd0;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 8'd0;
         wr_data_q  <= 8'd0;
      end else begin
         scl_pipe_q <= scl_pipe_d;
         sda_pipe_q <= sda_pipe_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         for (int i = 0; i < 256; i++) begin
            mem_q[i] <= INIT_VALUE;
         end
      end else if (mem_we) begin
         mem_q[ptr_q] <= rx_byte;
      end
   end

endmodule

// File: tb/tb_iic_slave.sv
// tb/tb_iic_slave.sv - self-checking bench for iic_slave
`timescale 1ns/1ps
module tb_iic_slave;
   localparam int Q = 100;

   logic sys_clk   = 1'b0;
   logic sys_rst   = 1'b0;
   logic scl       = 1'b1;
   logic m_sda_low = 1'b0;
   wire  sda;

   assign sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   iic_slave_if wr_if ();

   iic_slave #(
      .DEVICE_ADDR (7'b1010000),
      .ADDR_16BIT  (1'b1),
      .INIT_VALUE  (8'hFF)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .scl     (scl),
      .sda     (sda),
      .wr_if   (wr_if)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   int         wr_count = 0;
   logic [7:0] log_addr [64];
   logic [7:0] log_data [64];

   always @(negedge sys_clk) begin
      if (wr_if.wr_valid === 1'b1) begin
         if (wr_count < 64) begin
            log_addr[wr_count] = wr_if.wr_addr;
            log_data[wr_count] = wr_if.wr_data;
         end
         wr_count = wr_count + 1;
      end
   end

   typedef struct {
      bit          is_read;
      logic [15:0] addr;
      logic [7:0]  data;
   } vec_t;

   vec_t       vecs [8];
   logic       nack_acc;
   logic       abit;
   logic [7:0] rd_buf [4];
   int         wr_before;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic start_cond();
      m_sda_low = 1'b0; #(Q);
      scl = 1'b1;       #(Q);
      m_sda_low = 1'b1; #(Q);
      scl = 1'b0;       #(Q);
   endtask

   task automatic stop_cond();
      m_sda_low = 1'b1; #(Q);
      scl = 1'b1;       #(Q);
      m_sda_low = 1'b0; #(Q);
   endtask

   task automatic send_bit(input logic b);
      m_sda_low = ~b; #(Q);
      scl = 1'b1;     #(2*Q);
      scl = 1'b0;     #(Q);
   endtask

   task automatic recv_bit(output logic b);
      m_sda_low = 1'b0; #(Q);
      scl = 1'b1;       #(Q);
      b = sda;          #(Q);
      scl = 1'b0;       #(Q);
   endtask

   task automatic wb(input logic [7:0] v);
      logic a;
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(a);
      nack_acc = nack_acc | a;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         v[i] = b;
      end
      send_bit(nack);
   endtask

   task automatic set_addr(input logic [15:0] a);
      start_cond();
      wb(8'hA0);
      wb(a[15:8]);
      wb(a[7:0]);
   endtask

   task automatic rand_read(input logic [15:0] a, input int n);
      set_addr(a);
      start_cond();
      wb(8'hA1);
      for (int i = 0; i < n; i++) read_byte(i == n - 1, rd_buf[i]);
      stop_cond();
      #(Q);
   endtask

   initial begin
      vecs[0] = '{1'b0, 16'h0001, 8'd23};
      vecs[1] = '{1'b1, 16'h0001, 8'd23};
      vecs[2] = '{1'b1, 16'h0050, 8'hFF};
      vecs[3] = '{1'b0, 16'h1234, 8'h5A};
      vecs[4] = '{1'b1, 16'h0034, 8'h5A};
      vecs[5] = '{1'b0, 16'h0070, 8'h00};
      vecs[6] = '{1'b1, 16'h0070, 8'h00};
      vecs[7] = '{1'b1, 16'h0002, 8'hFF};

      #(53);
      check("rst_sda",      32'(sda), 1);
      check("rst_busy",     32'(wr_if.busy), 0);
      check("rst_wr_valid", 32'(wr_if.wr_valid), 0);
      check("rst_wr_addr",  32'(wr_if.wr_addr), 0);
      check("rst_wr_data",  32'(wr_if.wr_data), 0);
      sys_rst = 1'b1;
      #(4*Q);

      // Current-address read straight after power-up
      nack_acc = 1'b0;
      start_cond();
      wb(8'hA1);
      check("pu_busy_on", 32'(wr_if.busy), 1);
      read_byte(1'b0, rd_buf[0]);
      read_byte(1'b1, rd_buf[1]);
      stop_cond();
      #(Q);
      check("pu_ack",      32'(nack_acc), 0);
      check("pu_byte0",    32'(rd_buf[0]), 32'hFF);
      check("pu_byte1",    32'(rd_buf[1]), 32'hFF);
      check("pu_ptr",      32'(dut.ptr_q), 2);
      check("pu_busy_off", 32'(wr_if.busy), 0);

      for (int i = 0; i < 8; i++) begin
         nack_acc = 1'b0;
         if (!vecs[i].is_read) begin
            wr_before = wr_count;
            set_addr(vecs[i].addr);
            wb(vecs[i].data);
            stop_cond();
            #(Q);
            check($sformatf("vec%0d_ack", i),     32'(nack_acc), 0);
            check($sformatf("vec%0d_wrcnt", i),   32'(wr_count), 32'(wr_before + 1));
            check($sformatf("vec%0d_wraddr", i),  32'(log_addr[wr_before]), 32'(vecs[i].addr[7:0]));
            check($sformatf("vec%0d_wrdata", i),  32'(log_data[wr_before]), 32'(vecs[i].data));
         end else begin
            rand_read(vecs[i].addr, 1);
            check($sformatf("vec%0d_ack", i),  32'(nack_acc), 0);
            check($sformatf("vec%0d_data", i), 32'(rd_buf[0]), 32'(vecs[i].data));
         end
      end

      // Address mismatch: 0xA2 must be NACKed and everything after it ignored
      wr_before = wr_count;
      nack_acc = 1'b0;
      start_cond();
      wb(8'hA2);
      check("mis_nack", 32'(nack_acc), 1);
      check("mis_busy", 32'(wr_if.busy), 0);
      wb(8'h00);
      wb(8'h01);
      wb(8'h77);
      stop_cond();
      #(Q);
      check("mis_wrcnt", 32'(wr_count), 32'(wr_before));
      nack_acc = 1'b0;
      rand_read(16'h0001, 1);
      check("mis_array", 32'(rd_buf[0]), 23);

      // Sequential write across the 0xFF -> 0x00 wrap
      wr_before = wr_count;
      nack_acc = 1'b0;
      set_addr(16'h00FE);
      wb(8'h11);
      wb(8'h22);
      wb(8'h33);
      stop_cond();
      #(Q);
      check("wrap_ack",   32'(nack_acc), 0);
      check("wrap_wrcnt", 32'(wr_count), 32'(wr_before + 3));
      check("wrap_a0", 32'(log_addr[wr_before]),     32'hFE);
      check("wrap_a1", 32'(log_addr[wr_before + 1]), 32'hFF);
      check("wrap_a2", 32'(log_addr[wr_before + 2]), 32'h00);
      check("wrap_d2", 32'(log_data[wr_before + 2]), 32'h33);
      rand_read(16'h00FE, 3);
      check("wrap_r0", 32'(rd_buf[0]), 32'h11);
      check("wrap_r1", 32'(rd_buf[1]), 32'h22);
      check("wrap_r2", 32'(rd_buf[2]), 32'h33);

      // STOP after 5 data bits must not write anything
      wr_before = wr_count;
      set_addr(16'h0040);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      stop_cond();
      #(Q);
      check("abort_state", 32'(dut.state_q), 0);
      check("abort_busy",  32'(wr_if.busy), 0);
      check("abort_wrcnt", 32'(wr_count), 32'(wr_before));
      rand_read(16'h0040, 1);
      check("abort_data", 32'(rd_buf[0]), 32'hFF);

      // Reset while the target drives bit 7 (0) of address 0x70
      nack_acc = 1'b0;
      set_addr(16'h0070);
      start_cond();
      wb(8'hA1);
      check("rstrd_ack",     32'(nack_acc), 0);
      check("rstrd_drive",   32'(sda), 0);
      sys_rst = 1'b0;
      #1;
      check("rstrd_release", 32'(sda), 1);
      check("rstrd_busy",    32'(wr_if.busy), 0);
      #(Q);
      sys_rst = 1'b1;
      #(Q);
      scl = 1'b1;
      #(2*Q);
      rand_read(16'h0070, 1);
      check("rstrd_data", 32'(rd_buf[0]), 32'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iic_slave.md
Name: iic_slave

Overview:
- Synthesizable I2C target (responder) emulating a 24Cxx-style EEPROM with a 256-byte internal register array.
- Answers the team's iic_driver master over the same open-drain SCL/SDA pair.
- Used on-board as a loopback partner and in simulation as the driver's bus model.
- Oversamples SCL/SDA with sys_clk; never drives SCL (no clock stretching).

Parameters:
- DEVICE_ADDR, 7'b1010000, 7-bit target address matched against the first byte after START.
- ADDR_16BIT, 1'b1, 1 = two word-address bytes (high, then low); 0 = one byte. Only the low 8 bits index the array.
- INIT_VALUE, 8'hFF, reset content of every array byte.

Ports:
- sys_clk  input  1  system clock; must be at least 20x the SCL frequency.
- sys_rst  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  I2C data; driven 1'b0 or 1'bz only.
- wr_valid  output  1  one-cycle pulse when a data byte is written into the array.
- wr_addr  output  8  array index of that write.
- wr_data  output  8  byte written.
- busy  output  1  high from an addressed START (address match) until STOP.

Behaviour:
- Reset (sys_rst=0, async): state IDLE, sda released (z), wr_valid=0, wr_addr=0, wr_data=0, busy=0, address pointer=0, array=INIT_VALUE.
- Input conditioning: 2-FF synchronizer on scl and sda, then a 1-cycle-delayed copy for edge detect. Events are recognised 3 sys_clk after the pin change.
- START: sda falls while scl is high. Valid in any state, including mid-byte; it forces DEV_ADDR with bit count 0. This also covers repeated START.
- STOP: sda rises while scl is high. Valid in any state; it forces IDLE, releases sda and clears busy.
- Sampling: bits are sampled MSB first on the detected scl rising edge.
- Driving: sda drive changes only on the detected scl falling edge.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits.
    - Bits[7:1]==DEVICE_ADDR: go to ACK_DEV and set busy.
    - Otherwise: go to IGNORE, leave sda released, wait for START/STOP.
  - ACK_DEV: drive low for one SCL period. Then R/W=0 goes to ADDR_H (or ADDR_L if ADDR_16BIT=0); R/W=1 goes to RD_DATA.
  - ADDR_H: receive byte and discard it (array is 256 bytes), ACK, go to ADDR_L.
  - ADDR_L: receive byte into the pointer, ACK, go to WR_DATA.
  - WR_DATA: receive byte, then at the 8th rising edge:
    - array[pointer] <= byte;
    - wr_valid pulses 1 cycle with wr_addr=pointer and wr_data=byte;
    - pointer increments modulo 256 (0xFF wraps to 0x00).
    - Then ACK and stay in WR_DATA.
  - RD_DATA: on the falling edge after ACK_DEV or after a master ACK, load array[pointer] and present its MSB. Drive 0 as low and 1 as z. After 8 bits, increment the pointer modulo 256, release sda, go to RD_ACK.
  - RD_ACK: sample the master bit. 0 (ACK) goes to RD_DATA with the next byte; 1 (NACK) goes to IGNORE until STOP/START.
- Random read sequence: START, dev+W, address byte(s), repeated START, dev+R. The repeated START leaves the pointer at its loaded value.
- Mid-operation reset releases sda within the same cycle (async) and drops any partial byte.
- STOP during WR_DATA with fewer than 8 bits leaves the array and pointer untouched.
- busy and sda are unaffected by SCL glitches while scl is low; SDA changes only count as START/STOP when scl is high.

Test Plan:
- Write then read: master write 8'd23 to word address 16'd1, STOP, then random read of 16'd1.
  - Target ACKs all 4 write bytes; wr_valid pulses once with wr_addr=1, wr_data=23.
  - Read returns 23; a master LED-style compare (data==23) asserts.
- Address mismatch: first byte 0xA2 (address 0x51).
  - Ninth bit reads 1 (NACK); busy stays 0; no wr_valid; array unchanged.
- Sequential write wrap: address 0x00FE, data 0x11, 0x22, 0x33.
  - Writes land at 0xFE, 0xFF, 0x00.
  - A sequential read from 0xFE with master ACK, ACK, NACK returns 0x11, 0x22, 0x33.
- Abort: STOP after 5 bits of a data byte, then a fresh read of that address.
  - Original content (INIT_VALUE 0xFF) is returned; state is IDLE after the STOP.
- Reset mid-read: assert sys_rst low while the target drives sda low during a read.
  - sda becomes z immediately; busy=0.
  - After release, the next transaction at the same address reads 0xFF.
- Unaddressed read at power-up: START, dev+R, read 2 bytes with ACK then NACK, STOP.
  - Data is 0xFF, 0xFF from pointer 0; pointer ends at 2.
